lsu_issue_ctrl: RTL and testbench

- Initiator side of the data-memory access handshake; the memory unit is the responder.
- Accepts decoded RV32I load/store operations from the execute stage and computes the effective address.
- Checks alignment, formats store data and byte strobes, then issues a one-cycle start pulse and waits for done.
- Aligns and extends load data and presents a register-file write-back; raises an exception record on misalignment, illegal funct3 or responder timeout.

---
 rtl/lsu_issue_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lsu_issue_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_issue_ctrl.sv
// Load/store issue controller: computes the effective address, formats store data and
// strobes, runs the start/done handshake with the memory unit, and aligns load data.
module lsu_issue_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_base,
  input  logic [31:0]       in_src,
  input  logic [31:0]       in_imm,
  input  logic [4:0]        in_rd,
  output logic              mem_start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_done,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              exc_valid,
  output logic [1:0]        exc_cause,
  output logic [31:0]       exc_addr,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ERR} state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  state_t      state, state_next;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] ea_q, src_q, rdata_q;
  logic [4:0]  rd_q;
  logic [7:0]  cnt_q;
  logic [1:0]  cause_q;

  logic [31:0] ea_in;
  logic        accept, illegal_in, misalign_in, fault_in;
  logic [7:0]  cnt_inc;
  logic [1:0]  sh;
  logic [31:0] w;

  assign ea_in   = in_base + in_imm;
  assign accept  = in_valid && in_ready;
  assign cnt_inc = cnt_q + 8'd1;
  assign sh      = ea_q[1:0];
  assign w       = rdata_q >> {sh, 3'b000};

  assign illegal_in = in_is_store ? (in_funct3 > 3'b010)
                                  : (in_funct3 == 3'b011 || in_funct3 > 3'b101);
  // funct3[1:0] encodes width: 01 halfword, 10 word (LBU/LHU share the low bits).
  assign misalign_in = (in_funct3[1:0] == 2'b01 && ea_in[0]) ||
                       (in_funct3[1:0] == 2'b10 && ea_in[1:0] != 2'b00);
  assign fault_in    = illegal_in || misalign_in;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      ea_q       <= '0;
      src_q      <= '0;
      rdata_q    <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      cause_q    <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (accept) begin
          is_store_q <= in_is_store;
          funct3_q   <= in_funct3;
          ea_q       <= ea_in;
          src_q      <= in_src;
          rd_q       <= in_rd;
          cause_q    <= illegal_in ? 2'b11 : {1'b0, in_is_store};
        end
        S_ISSUE: cnt_q <= '0;
        S_WAIT: begin
          if (mem_done) begin
            rdata_q <= mem_rdata;
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_inc == TIMEOUT_LIM) cause_q <= 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = rst && (state == S_IDLE);
    mem_start  = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wstrb  = '0;
    mem_wdata  = '0;
    wb_valid   = 1'b0;
    wb_rd      = '0;
    wb_data    = '0;
    exc_valid  = 1'b0;
    exc_cause  = '0;
    exc_addr   = '0;
    busy       = (state != S_IDLE);

    if (state == S_ISSUE || state == S_WAIT) begin
      mem_addr = ea_q[ADDR_W+1:2];
      mem_we   = is_store_q;
      if (is_store_q) begin
        case (funct3_q[1:0])
          2'b00: begin
            mem_wdata = {4{src_q[7:0]}};
            mem_wstrb = 4'b0001 << sh;
          end
          2'b01: begin
            mem_wdata = {2{src_q[15:0]}};
            mem_wstrb = 4'b0011 << sh;
          end
          default: begin
            mem_wdata = src_q;
            mem_wstrb = 4'b1111;
          end
        endcase
      end
    end

    case (state)
      S_IDLE: if (accept) state_next = fault_in ? S_ERR : S_ISSUE;
      S_ISSUE: begin
        mem_start  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (mem_done)                  state_next = S_RESP;
        else if (cnt_inc == TIMEOUT_LIM) state_next = S_ERR;
      end
      S_RESP: begin
        wb_valid   = !is_store_q && (rd_q != 5'd0);
        state_next = S_IDLE;
        if (wb_valid) begin
          wb_rd = rd_q;
          case (funct3_q)
            3'b000:  wb_data = {{24{w[7]}}, w[7:0]};
            3'b100:  wb_data = {24'd0, w[7:0]};
            3'b001:  wb_data = {{16{w[15]}}, w[15:0]};
            3'b101:  wb_data = {16'd0, w[15:0]};
            default: wb_data = w;
          endcase
        end
      end
      S_ERR: begin
        exc_valid  = 1'b1;
        exc_cause  = cause_q;
        exc_addr   = ea_q;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_issue_ctrl.sv
// Directed bench for lsu_issue_ctrl: vector table of single operations plus
// hand-written timeout, reset-in-flight and early-done sequences.
module tb_lsu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_base, in_src, in_imm;
  logic [4:0]  in_rd;
  logic        mem_start, mem_we, mem_done;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_rdata;
  logic        wb_valid, exc_valid, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;
  logic [1:0]  exc_cause;

  always #5 clk = ~clk;

  lsu_issue_ctrl #(.ADDR_W(10), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_base(in_base), .in_src(in_src), .in_imm(in_imm),
    .in_rd(in_rd),
    .mem_start(mem_start), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr),
    .busy(busy)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] base, imm, src;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          k;
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] ea;
    logic [9:0]  addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        wb;
    logic [31:0] wb_data;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] imm, input logic [31:0] src, input logic [4:0] rd);
    in_valid = 1'b1; in_is_store = st; in_funct3 = f3;
    in_base = base; in_imm = imm; in_src = src; in_rd = rd;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;

    //          st  f3      base          imm           src           rd  rdata         k  flt cause ea           addr     strb     wdata         wb  wb_data
    vecs[0]  = '{0, 3'b010, 32'h00000100, 32'h00000004, 32'h0,        5,  32'hDEADBEEF, 2, 0, 2'b00, 32'h00000104, 10'h041, 4'b0000, 32'h0,        1, 32'hDEADBEEF};
    vecs[1]  = '{0, 3'b000, 32'h00000200, 32'h00000003, 32'h0,        6,  32'h80FF1234, 1, 0, 2'b00, 32'h00000203, 10'h080, 4'b0000, 32'h0,        1, 32'hFFFFFF80};
    vecs[2]  = '{0, 3'b100, 32'h00000200, 32'h00000003, 32'h0,        7,  32'h80FF1234, 3, 0, 2'b00, 32'h00000203, 10'h080, 4'b0000, 32'h0,        1, 32'h00000080};
    vecs[3]  = '{0, 3'b001, 32'h00000200, 32'h00000002, 32'h0,        8,  32'h8001ABCD, 1, 0, 2'b00, 32'h00000202, 10'h080, 4'b0000, 32'h0,        1, 32'hFFFF8001};
    vecs[4]  = '{0, 3'b101, 32'h00001000, 32'hFFFFFFFE, 32'h0,        9,  32'h8001ABCD, 2, 0, 2'b00, 32'h00000FFE, 10'h3FF, 4'b0000, 32'h0,        1, 32'h00008001};
    vecs[5]  = '{1, 3'b000, 32'h00000000, 32'h00000006, 32'h000000A5, 3,  32'h0,        1, 0, 2'b00, 32'h00000006, 10'h001, 4'b0100, 32'hA5A5A5A5, 0, 32'h0};
    vecs[6]  = '{1, 3'b001, 32'h00000010, 32'h00000002, 32'h1234BEEF, 0,  32'h0,        2, 0, 2'b00, 32'h00000012, 10'h004, 4'b1100, 32'hBEEFBEEF, 0, 32'h0};
    vecs[7]  = '{1, 3'b010, 32'h00000400, 32'h00000010, 32'hCAFEF00D, 0,  32'h0,        1, 0, 2'b00, 32'h00000410, 10'h104, 4'b1111, 32'hCAFEF00D, 0, 32'h0};
    vecs[8]  = '{0, 3'b010, 32'hFFFFFFFC, 32'h00000008, 32'h0,        0,  32'h00000011, 1, 0, 2'b00, 32'h00000004, 10'h001, 4'b0000, 32'h0,        0, 32'h0};
    vecs[9]  = '{1, 3'b010, 32'h00000100, 32'h00000002, 32'h0,        0,  32'h0,        1, 1, 2'b01, 32'h00000102, 10'h000, 4'b0000, 32'h0,        0, 32'h0};
    vecs[10] = '{0, 3'b011, 32'h00000100, 32'h00000000, 32'h0,        1,  32'h0,        1, 1, 2'b11, 32'h00000100, 10'h000, 4'b0000, 32'h0,        0, 32'h0};
    vecs[11] = '{0, 3'b010, 32'h00000100, 32'h00000001, 32'h0,        1,  32'h0,        1, 1, 2'b00, 32'h00000101, 10'h000, 4'b0000, 32'h0,        0, 32'h0};
    vecs[12] = '{0, 3'b001, 32'h00000200, 32'h00000005, 32'h0,        1,  32'h0,        1, 1, 2'b00, 32'h00000205, 10'h000, 4'b0000, 32'h0,        0, 32'h0};
    vecs[13] = '{1, 3'b100, 32'h00000000, 32'h00000003, 32'h0,        0,  32'h0,        1, 1, 2'b11, 32'h00000003, 10'h000, 4'b0000, 32'h0,        0, 32'h0};

    rst = 1'b0; in_valid = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010;
    in_base = 32'h100; in_imm = 32'h0; in_src = 32'h0; in_rd = 5'd1;
    mem_done = 1'b0; mem_rdata = 32'h0;
    repeat (3) step();
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_start", mem_start, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_exc_valid", exc_valid, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      offer(v.st, v.f3, v.base, v.imm, v.src, v.rd);
      if (v.fault) begin
        check($sformatf("v%0d_exc_valid", i), exc_valid, 1);
        check($sformatf("v%0d_exc_cause", i), exc_cause, v.cause);
        check($sformatf("v%0d_exc_addr", i), exc_addr, v.ea);
        check($sformatf("v%0d_no_start", i), mem_start, 0);
        step();
        check($sformatf("v%0d_idle_ready", i), in_ready, 1);
      end else begin
        check($sformatf("v%0d_start", i), mem_start, 1);
        check($sformatf("v%0d_addr", i), mem_addr, v.addr);
        check($sformatf("v%0d_we", i), mem_we, v.st);
        if (v.st) begin
          check($sformatf("v%0d_wstrb", i), mem_wstrb, v.wstrb);
          check($sformatf("v%0d_wdata", i), mem_wdata, v.wdata);
        end
        step();
        check($sformatf("v%0d_start_once", i), mem_start, 0);
        repeat (v.k - 1) step();
        check($sformatf("v%0d_addr_held", i), mem_addr, v.addr);
        mem_done = 1'b1; mem_rdata = v.rdata;
        step();
        mem_done = 1'b0; mem_rdata = 32'h0;
        check($sformatf("v%0d_wb_valid", i), wb_valid, v.wb);
        if (v.wb) begin
          check($sformatf("v%0d_wb_rd", i), wb_rd, v.rd);
          check($sformatf("v%0d_wb_data", i), wb_data, v.wb_data);
        end
        check($sformatf("v%0d_no_exc", i), exc_valid, 0);
        check($sformatf("v%0d_we_off", i), mem_we, 0);
        step();
        check($sformatf("v%0d_idle_ready", i), in_ready, 1);
      end
    end

    // Timeout: 15 WAIT cycles without done, then a late done is ignored.
    offer(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 5'd4);
    n = 0;
    while (!exc_valid && n < 40) begin
      step();
      n++;
    end
    check("to_latency", n, 16);
    check("to_cause", exc_cause, 2'b10);
    check("to_addr", exc_addr, 32'h300);
    repeat (2) step();
    mem_done = 1'b1; mem_rdata = 32'h55AA55AA;
    check("to_ready", in_ready, 1);
    step();
    mem_done = 1'b0;
    check("to_late_wb", wb_valid, 0);
    check("to_late_exc", exc_valid, 0);
    check("to_late_busy", busy, 0);

    // Reset while waiting: everything abandoned, done after reset ignored.
    offer(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 5'd2);
    step();
    rst = 1'b0;
    step();
    mem_done = 1'b1; mem_rdata = 32'h77777777;
    check("rw_busy", busy, 0);
    check("rw_mem_start", mem_start, 0);
    check("rw_mem_addr", mem_addr, 0);
    check("rw_in_ready", in_ready, 0);
    step();
    mem_done = 1'b0;
    check("rw_wb", wb_valid, 0);
    check("rw_exc", exc_valid, 0);
    rst = 1'b1;
    #1;
    check("rw_ready_after", in_ready, 1);
    step();
    check("rw_wb_after", wb_valid, 0);
    check("rw_busy_after", busy, 0);

    // mem_done during ISSUE is ignored; the later WAIT-cycle data is the one returned.
    offer(1'b0, 3'b010, 32'h80, 32'h0, 32'h0, 5'd10);
    mem_done = 1'b1; mem_rdata = 32'h0BADBAD0;
    step();
    mem_done = 1'b0;
    step();
    check("ei_busy", busy, 1);
    check("ei_no_wb", wb_valid, 0);
    mem_done = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_done = 1'b0;
    check("ei_wb_valid", wb_valid, 1);
    check("ei_wb_data", wb_data, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
